// File: rtl/serialize_rr_arbiter.sv
// Round-robin arbiter that shares one wide-word to narrow-chunk serializer between NUM_IN producers.
// Optional macro SERIALIZE_RR_ARBITER_BACK2BACK_EN removes the idle bubble between consecutive words.
module serialize_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 8,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       din_valid,
    input  logic [NUM_IN*DIN_W-1:0] din_data,
    output logic [NUM_IN-1:0]       din_ready,
    output logic                    dout_valid,
    output logic [ID_W+DOUT_W:0]    dout_data,
    input  logic                    dout_ready
);

    localparam int RATIO = DIN_W / DOUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (NUM_IN < 2) begin : g_bad_num_in
            $error("serialize_rr_arbiter: NUM_IN must be at least 2");
        end
        if ((DIN_W % DOUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("serialize_rr_arbiter: DIN_W must be a multiple of DOUT_W with ratio >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] count;

    logic [DIN_W-1:0]  word;
    logic [DOUT_W-1:0] chunk;
    logic              is_last;
    logic              beat_done;
    logic              word_done;
    logic [ID_W:0]     idle_pick;

    // Returns {found, index} of the first request after ptr, wrapping; lowest offset wins.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_IN-1:0] req,
                                               input logic [ID_W-1:0]   ptr);
        logic [ID_W:0] result;
        int            idx;
        result = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (req[idx]) begin
                result = {1'b1, ID_W'(idx)};
            end
        end
        return result;
    endfunction

    assign word      = din_data[int'(grant)*DIN_W +: DIN_W];
    assign chunk     = word[int'(count)*DOUT_W +: DOUT_W];
    assign is_last   = (count == CNT_W'(RATIO - 1));
    assign idle_pick = rr_pick(din_valid, rr_ptr);

    // Output path depends only on registered state and the granted producer, never on dout_ready.
    assign dout_valid = (state == SEND) && din_valid[grant];
    assign dout_data  = (state == SEND) ? {is_last, grant, chunk} : '0;
    assign beat_done  = dout_valid && dout_ready;
    assign word_done  = beat_done && is_last;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        din_ready = '0;
        if (word_done) begin
            din_ready[grant] = 1'b1;
        end
    end

`ifdef SERIALIZE_RR_ARBITER_BACK2BACK_EN
    logic [ID_W:0]     next_pick;
    logic [NUM_IN-1:0] other_req;

    // The holder's valid belongs to the word being consumed right now, so it cannot win again.
    always_comb begin
        other_req        = din_valid;
        other_req[grant] = 1'b0;
    end

    assign next_pick = rr_pick(other_req, grant);
`endif

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= ID_W'(NUM_IN - 1);
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[ID_W]) begin
                        grant <= idle_pick[ID_W-1:0];
                        count <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (beat_done) begin
                        if (!is_last) begin
                            count <= count + 1'b1;
                        end else begin
                            rr_ptr <= grant;
                            count  <= '0;
`ifdef SERIALIZE_RR_ARBITER_BACK2BACK_EN
                            if (next_pick[ID_W]) begin
                                grant <= next_pick[ID_W-1:0];
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serialize_rr_arbiter.sv
// Self-checking bench for serialize_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level round-robin model.
module tb_serialize_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int OW  = 8;
    localparam int IW  = 2;
    localparam int R   = DW / OW;
    localparam int DOW = 1 + IW + OW;
`ifdef SERIALIZE_RR_ARBITER_BACK2BACK_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    din_valid;
    logic [N*DW-1:0] din_data;
    logic [N-1:0]    din_ready;
    logic            dout_valid;
    logic [DOW-1:0]  dout_data;
    logic            dout_ready;

    always #5 clk = ~clk;

    serialize_rr_arbiter #(.NUM_IN(N), .DIN_W(DW), .DOUT_W(OW), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_data  (din_data),
        .din_ready (din_ready),
        .dout_valid(dout_valid),
        .dout_data (dout_data),
        .dout_ready(dout_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who is being served, which beat is next, who was served last.
    int m_busy, m_src, m_beat, m_last;
    int cyc = 0;
    logic [DOW-1:0] beats[$];
    int             beat_cyc[$];
    int             rdy_cyc[$];
    logic [N-1:0]   last_ready;
    logic           prev_stall;
    logic [DOW-1:0] prev_data;

    function automatic int rr_search(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_src = 0; m_beat = 0; m_last = N - 1;
        prev_stall = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 unit after the rising edge.
    task automatic step();
        logic           ev;
        logic [DOW-1:0] ed;
        logic [N-1:0]   er;
        logic [DW-1:0]  w;
        int nb, ns, nbt, nl, s;
        @(negedge clk);
        w  = din_data[m_src*DW +: DW];
        ev = (m_busy != 0) && din_valid[m_src];
        ed = {(m_beat == R - 1), IW'(m_src), w[m_beat*OW +: OW]};
        er = '0;
        if (ev && dout_ready && m_beat == R - 1) er[m_src] = 1'b1;
        check("dout_valid", dout_valid, ev);
        check("din_ready", din_ready, er);
        if (ev) check("dout_data", dout_data, ed);
        if (prev_stall && dout_valid) check("stall_hold", dout_data, prev_data);
        prev_stall = dout_valid && !dout_ready;
        prev_data  = dout_data;
        if (dout_valid && dout_ready) begin
            beats.push_back(dout_data);
            beat_cyc.push_back(cyc);
        end
        if (din_ready != '0) rdy_cyc.push_back(cyc);
        last_ready = din_ready;

        nb = m_busy; ns = m_src; nbt = m_beat; nl = m_last;
        if (m_busy == 0) begin
            s = rr_search(din_valid, m_last);
            if (s >= 0) begin nb = 1; ns = s; nbt = 0; end
        end else if (ev && dout_ready) begin
            if (m_beat < R - 1) begin
                nbt = m_beat + 1;
            end else begin
                nl = m_src; nb = 0; nbt = 0;
`ifdef SERIALIZE_RR_ARBITER_BACK2BACK_EN
                s = rr_search(din_valid & ~(N'(1) << m_src), m_src);
                if (s >= 0) begin nb = 1; ns = s; end
`endif
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_src = ns; m_beat = nbt; m_last = nl;
        cyc++;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_din_ready", din_ready, '0);
        check("rst_dout_data", dout_data, '0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_logs();
        beats.delete(); beat_cyc.delete(); rdy_cyc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int start;
        logic [DOW-1:0] exp_a[4];
        int exp_ord[6];
        int exp_alt[4];
        int bp_pat[7];
        int bp_cyc[4];
        logic [7:0] bp_chunk[4];

        din_valid  = '0;
        din_data   = '0;
        dout_ready = 1'b0;
        apply_reset(3);

        // Single requester
        exp_a = '{{1'b0, 2'd1, 8'hD4}, {1'b0, 2'd1, 8'hC3}, {1'b0, 2'd1, 8'hB2}, {1'b1, 2'd1, 8'hA1}};
        din_data[1*DW +: DW] = 32'hA1B2C3D4;
        din_valid  = 4'b0010;
        dout_ready = 1'b1;
        clear_logs();
        start = cyc;
        repeat (5) step();
        din_valid = '0;
        repeat (2) step();
        check("single_nbeats", beats.size(), 4);
        check("single_nready", rdy_cyc.size(), 1);
        if (beats.size() >= 4 && rdy_cyc.size() >= 1) begin
            for (int i = 0; i < 4; i++) check("single_beat", beats[i], exp_a[i]);
            check("single_latency", beat_cyc[0] - start, 1);
            check("single_ready_cyc", rdy_cyc[0], beat_cyc[3]);
        end

        // All requesters from reset
        apply_reset(2);
        exp_ord = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) din_data[i*DW +: DW] = 32'h10203040 * (i + 1);
        din_valid  = 4'hF;
        dout_ready = 1'b1;
        clear_logs();
        repeat (32) step();
        check("all_nbeats_ge24", beats.size() >= 24, 1'b1);
        if (beats.size() >= 24) begin
            for (int k = 0; k < 6; k++) begin
                check("all_order", beats[4*k][9:8], exp_ord[k]);
                check("all_first_not_last", beats[4*k][10], 1'b0);
                check("all_last_on_4th", beats[4*k+3][10], 1'b1);
            end
        end

        // Backpressure
        apply_reset(2);
        bp_pat   = '{1, 0, 0, 1, 0, 1, 1};
        bp_cyc   = '{1, 4, 6, 7};
        bp_chunk = '{8'h44, 8'h33, 8'h22, 8'h11};
        din_data[0 +: DW] = 32'h11223344;
        din_valid  = 4'b0001;
        dout_ready = 1'b1;
        clear_logs();
        start = cyc;
        step();
        for (int p = 0; p < 7; p++) begin
            dout_ready = bp_pat[p][0];
            step();
        end
        din_valid  = '0;
        dout_ready = 1'b1;
        repeat (2) step();
        check("bp_nbeats", beats.size(), 4);
        if (beats.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("bp_chunk", beats[i][7:0], bp_chunk[i]);
                check("bp_cycle", beat_cyc[i] - start, bp_cyc[i]);
            end
        end

        // Reset mid-word
        apply_reset(2);
        din_data[2*DW +: DW] = 32'hDEADBEEF;
        din_valid  = 4'b0100;
        dout_ready = 1'b1;
        repeat (3) step();
        #2;
        apply_reset(1);
        clear_logs();
        start = cyc;
        repeat (5) step();
        din_valid = '0;
        repeat (2) step();
        check("rstmid_nbeats", beats.size(), 4);
        if (beats.size() >= 4) begin
            check("rstmid_restart", beats[0], {1'b0, 2'd2, 8'hEF});
            check("rstmid_latency", beat_cyc[0] - start, 1);
            check("rstmid_last", beats[3], {1'b1, 2'd2, 8'hDE});
        end

        // Back-to-back between requesters 0 and 3
        apply_reset(2);
        exp_alt = '{0, 3, 0, 3};
        din_data[0*DW +: DW] = 32'h0A0B0C0D;
        din_data[3*DW +: DW] = 32'h3A3B3C3D;
        din_valid  = 4'b1001;
        dout_ready = 1'b1;
        clear_logs();
        repeat (24) step();
        check("b2b_nbeats_ge16", beats.size() >= 16, 1'b1);
        if (beats.size() >= 16) begin
            for (int k = 0; k < 4; k++) check("b2b_id", beats[4*k][9:8], exp_alt[k]);
            for (int k = 0; k < 3; k++) check("b2b_gap", beat_cyc[4*k+4] - beat_cyc[4*k+3] - 1, EXP_GAP);
        end

        // Requester drops valid mid-word
        apply_reset(2);
        din_data[0*DW +: DW] = 32'h55667788;
        din_data[1*DW +: DW] = 32'h99AABBCC;
        din_valid  = 4'b0001;
        dout_ready = 1'b1;
        clear_logs();
        repeat (2) step();
        din_valid = 4'b0010;
        #1;
        check("drop_dout_valid", dout_valid, 1'b0);
        repeat (2) step();
        check("drop_nbeats", beats.size(), 1);
        din_valid = 4'b0011;
        repeat (3) step();
        din_valid = 4'b0010;
        check("drop_resume_nbeats", beats.size(), 4);
        if (beats.size() >= 4) begin
            check("drop_resume_beat2", beats[1], {1'b0, 2'd0, 8'h77});
            check("drop_resume_last", beats[3], {1'b1, 2'd0, 8'h55});
        end
        repeat (6) step();

        // Randomized legal traffic
        apply_reset(2);
        din_valid = '0;
        for (int it = 0; it < 1500; it++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!din_valid[i] && $urandom_range(0, 2) == 0) begin
                    din_valid[i] = 1'b1;
                    din_data[i*DW +: DW] = $urandom;
                end
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) begin
                    din_valid[i] = $urandom_range(0, 1) != 0;
                    din_data[i*DW +: DW] = $urandom;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serialize_rr_arbiter.md
# serialize_rr_arbiter

- Shares one word-to-chunk serializer datapath between `NUM_IN` wide-word producers.
- Grants one requester at a time using round-robin priority and holds the grant for every chunk of that word.
- Emits each word as `DIN_W/DOUT_W` narrow beats on a single DTI producer, tagged with source id and a last flag.
- Sits between multiple wide-word sources and one narrow link or FIFO.

## Interface

Parameters:
- `NUM_IN`, 4: number of requesters; must be ≥2.
- `DIN_W`, 32: input word width.
- `DOUT_W`, 8: chunk width; `DIN_W` must be an integer multiple of `DOUT_W` with `RATIO = DIN_W/DOUT_W` ≥2. Any other combination is an elaboration error.
- `ID_W`, `$clog2(NUM_IN)`: source id width.

Ports:
- `clk`, in, 1: clock; all state is updated on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `din_valid`, in, `NUM_IN`: per-requester DTI valid.
- `din_data`, in, `NUM_IN*DIN_W`: requester `i` drives bits `[(i+1)*DIN_W-1 : i*DIN_W]`.
- `din_ready`, out, `NUM_IN`: per-requester DTI ready.
- `dout_valid`, out, 1: DTI valid.
- `dout_data`, out, `1+ID_W+DOUT_W`: field order is `{last, id, chunk}`.
- `dout_ready`, in, 1: DTI ready.

## Operation

State:
- `grant` (`ID_W` bits)
- `rr_ptr` (`ID_W` bits): the last requester served
- `count` (`$clog2(RATIO)` bits)
- FSM with states IDLE and SEND

IDLE:
- `dout_valid` = 0 and `din_ready` = 0.
- If any `din_valid` is high, pick the first requester found searching from `rr_ptr+1` upward, wrapping modulo `NUM_IN`.
- Register that choice into `grant`, set `count` = 0, and go to SEND.

SEND:
- `dout_valid` = `din_valid[grant]`.
- `chunk` = `din_data[grant]` bits `[(count+1)*DOUT_W-1 : count*DOUT_W]`, so chunk 0 (the LSBs) goes first.
- `id` = `grant`; `last` = (`count == RATIO-1`).
- On handshake (`dout_valid & dout_ready`) when not last: `count` increments.
- On a last-beat handshake:
  - `din_ready[grant]` = `dout_ready`; this is the only cycle in which any `din_ready` bit is high.
  - `rr_ptr` is set to `grant`, `count` is set to 0, and the FSM returns to IDLE (see Configuration).
- `din_ready` bits for all non-granted requesters are always 0.
- A requester must not drop `din_valid` mid-word (DTI rule). If it does, `dout_valid` falls with it, `count` and `grant` hold, and the FSM stays in SEND.
- Arbitration is fair: an asserted requester waits at most `NUM_IN-1` words.

## Timing

- Reset values: FSM = IDLE, `count` = 0, `grant` = 0, `rr_ptr` = `NUM_IN-1` (so requester 0 has top priority). Outputs: `dout_valid` = 0, `din_ready` = all 0, `dout_data` = 0.
- Reset is asynchronous. Assertion mid-word clears state immediately and the partial word is abandoned. A source still holding `din_valid` is re-arbitrated after release and its word restarts from chunk 0.
- Latency: first beat is 1 cycle after `din_valid` is seen in IDLE.
- The `dout` path is combinational from `din_data[grant]`, `din_valid[grant]` and registered state. There is no combinational path from `dout_ready` to `dout_valid`.
- `din_ready[grant]` depends combinationally on `dout_ready`.
- Throughput without back-to-back: `RATIO` beats per `RATIO+1` cycles.
- Under backpressure, `dout_data` stays stable while `dout_valid` is high and `dout_ready` is low.

## Configuration

- Macro: `SERIALIZE_RR_ARBITER_BACK2BACK_EN`.
- Defined:
  - On a last-beat handshake, round-robin arbitration runs in the same cycle over `din_valid`, with the just-served `grant` treated as `rr_ptr`.
  - The current grant holder's `din_valid` is excluded from this search because it is being consumed.
  - If a winner exists, `grant` loads it, `count` = 0 and the FSM stays in SEND. Otherwise it goes to IDLE.
  - Result: zero bubble cycles between words.
- Undefined: the FSM always returns to IDLE, giving one bubble cycle between words.

## Test plan

Configuration for all scenarios: `NUM_IN` = 4, `DIN_W` = 32, `DOUT_W` = 8.

- **Single requester:** requester 1 valid with 0xA1B2C3D4, `dout_ready` = 1.
  - `dout_data` sequence is `{0,1,D4}`, `{0,1,C3}`, `{0,1,B2}`, `{1,1,A1}`.
  - The first beat appears 1 cycle after valid.
  - `din_ready[1]` is high only during the 4th beat.
- **All requesters after reset:** all four requesters valid continuously from reset release.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each word is exactly 4 beats with last on beat 4.
- **Backpressure:** `dout_ready` pattern 1, 0, 0, 1, 0, 1, 1 on word 0x11223344.
  - Beats 44, 33, 22, 11 each advance only on handshake cycles.
  - `dout_data` is held during stalls.
- **Reset mid-word:** `rst` low after 2 beats of requester 2's word 0xDEADBEEF.
  - `dout_valid` goes to 0 immediately.
  - After release, requester 2's output restarts with chunk EF.
- **Back-to-back:** requesters 0 and 3 valid continuously, `dout_ready` = 1.
  - Gap between `last` of word N and the first beat of word N+1: 0 cycles with `SERIALIZE_RR_ARBITER_BACK2BACK_EN`, 1 cycle without.
  - The id alternates 0, 3, 0, 3.
- **Requester drops valid:** requester 0 drops `din_valid` after beat 1.
  - `dout_valid` = 0 while valid is low, and `count` holds at 1.
  - When valid returns, beat 2 resumes with the same grant.
